// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: fetch-stage instruction memory with a one-cycle registered
// read, stall hold, flush kill, a run-time load port and an optional
// post-reset sweep that clears every word to NOP_WORD.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   i_req, i_pc         fetch request and fetch address
//   i_stall, i_flush    hold the current output / kill the current output
//   i_we, i_waddr,
//   i_wdata             load-port write
//   o_out, o_out_pc     fetched word and the PC it came from (registered)
//   o_valid, o_err      live instruction / came from an out-of-range PC
//   o_busy              clear sweep in progress; requests and writes ignored
module instr_mem_pipe #(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       ADDR_W         = 6,
  parameter int unsigned       DEPTH          = 64,
  parameter logic [DATA_W-1:0] NOP_WORD       = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_out,
  output logic [ADDR_W-1:0] o_out_pc,
  output logic              o_valid,
  output logic              o_err,
  output logic              o_busy
);

  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_out, w_out_nxt;
  logic [ADDR_W-1:0]   r_out_pc, w_out_pc_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_err, w_err_nxt;
  logic                r_busy, w_busy_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_mem_we;
  logic [IDX_W-1:0]    w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  logic                w_pc_ok, w_wa_ok, w_wr_ok;
  logic [DATA_W-1:0]   w_rd_data;

  // Range checks are done one bit wider so DEPTH == 2**ADDR_W never trips them.
  assign w_pc_ok = ({1'b0, i_pc}    < DEPTH_X);
  assign w_wa_ok = ({1'b0, i_waddr} < DEPTH_X);
  assign w_wr_ok = i_we && w_wa_ok;

  // Write-first bypass: a same-edge write to the fetched address wins.
  assign w_rd_data = (w_wr_ok && (i_waddr == i_pc)) ? i_wdata
                                                    : r_mem[IDX_W'(i_pc)];

  // Next-state, memory write port and output register updates.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_out_nxt    = r_out;
    w_out_pc_nxt = r_out_pc;
    w_valid_nxt  = r_valid;
    w_err_nxt    = r_err;
    w_mem_we     = 1'b0;
    w_mem_addr   = IDX_W'(i_waddr);
    w_mem_wdata  = i_wdata;

    unique case (r_state)
      ST_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = IDX_W'(r_cnt);
        w_mem_wdata = NOP_WORD;
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        w_mem_we = w_wr_ok;
        if (i_flush) begin
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          w_out_nxt   = NOP_WORD;
        end else if (i_stall) begin
          // hold everything
        end else if (i_req) begin
          w_out_pc_nxt = i_pc;
          w_valid_nxt  = 1'b1;
          if (w_pc_ok) begin
            w_out_nxt = w_rd_data;
            w_err_nxt = 1'b0;
          end else begin
            w_out_nxt = NOP_WORD;
            w_err_nxt = 1'b1;
          end
        end else begin
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b0;
        end
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_INIT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) r_state <= ST_INIT;
      else                r_state <= ST_RUN;
      r_busy   <= CLEAR_ON_RESET;
      r_cnt    <= '0;
      r_out    <= NOP_WORD;
      r_out_pc <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= w_busy_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out    <= w_out_nxt;
      r_out_pc <= w_out_pc_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Storage array; contents survive reset and are cleared by the sweep.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  assign o_out    = r_out;
  assign o_out_pc = r_out_pc;
  assign o_valid  = r_valid;
  assign o_err    = r_err;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Testbench for instr_mem_pipe: two instances (DEPTH=64 and DEPTH=48) share
// the same stimulus; a per-instance behavioural model predicts each cycle's
// outputs into a queue and a monitor compares them after every clock edge.
module tb_instr_mem_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 6;

  logic          clk, rst_n;
  logic          req, stall, flush, we;
  logic [AW-1:0] pc, waddr;
  logic [DW-1:0] wdata;

  logic [DW-1:0] a_out, b_out;
  logic [AW-1:0] a_pc, b_pc;
  logic          a_valid, b_valid, a_err, b_err, a_busy, b_busy;

  instr_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_pc(pc), .i_stall(stall),
    .i_flush(flush), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .o_out(a_out), .o_out_pc(a_pc), .o_valid(a_valid), .o_err(a_err),
    .o_busy(a_busy));

  instr_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(48)) u_dut48 (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_pc(pc), .i_stall(stall),
    .i_flush(flush), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .o_out(b_out), .o_out_pc(b_pc), .o_valid(b_valid), .o_err(b_err),
    .o_busy(b_busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] out;
    logic [AW-1:0] pc;
    logic          valid;
    logic          err;
    logic          busy;
    string         tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;
  string g_tag = "reset";

  // Behavioural reference: a word array, a countdown of remaining clear
  // cycles, and the output fields updated by the documented priority rules.
  logic [DW-1:0] m_mem   [2][64];
  int            m_depth [2] = '{64, 48};
  int            m_left  [2];
  logic [DW-1:0] m_out   [2];
  logic [AW-1:0] m_pc    [2];
  logic          m_valid [2];
  logic          m_err   [2];

  task automatic model_step(input int k);
    exp_t e;
    if (!rst_n) begin
      m_left[k]  = m_depth[k];
      m_out[k]   = '0;
      m_pc[k]    = '0;
      m_valid[k] = 1'b0;
      m_err[k]   = 1'b0;
    end else if (m_left[k] > 0) begin
      m_mem[k][m_depth[k] - m_left[k]] = '0;
      m_left[k] = m_left[k] - 1;
    end else begin
      if (we && int'(waddr) < m_depth[k]) m_mem[k][waddr] = wdata;
      if (flush) begin
        m_valid[k] = 1'b0;
        m_err[k]   = 1'b0;
        m_out[k]   = '0;
      end else if (stall) begin
        // outputs unchanged
      end else if (req) begin
        m_pc[k]    = pc;
        m_valid[k] = 1'b1;
        if (int'(pc) < m_depth[k]) begin
          m_out[k] = m_mem[k][pc];
          m_err[k] = 1'b0;
        end else begin
          m_out[k] = '0;
          m_err[k] = 1'b1;
        end
      end else begin
        m_valid[k] = 1'b0;
        m_err[k]   = 1'b0;
      end
    end
    e.out   = m_out[k];
    e.pc    = m_pc[k];
    e.valid = m_valid[k];
    e.err   = m_err[k];
    e.busy  = (m_left[k] > 0);
    e.tag   = g_tag;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input logic r_req, input logic [AW-1:0] r_pc,
                       input logic r_stall, input logic r_flush,
                       input logic r_we, input logic [AW-1:0] r_wa,
                       input logic [DW-1:0] r_wd);
    @(negedge clk);
    rst_n = 1'b1;
    req = r_req; pc = r_pc; stall = r_stall; flush = r_flush;
    we = r_we; waddr = r_wa; wdata = r_wd;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      req = 1'b0; stall = 1'b0; flush = 1'b0; we = 1'b0;
      model_step(0);
      model_step(1);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  exp_t ea, eb;

  // Monitor: one expectation per instance per clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        ea = q0.pop_front();
        check({ea.tag, "/d64 out"},   32'(a_out),   32'(ea.out));
        check({ea.tag, "/d64 pc"},    32'(a_pc),    32'(ea.pc));
        check({ea.tag, "/d64 valid"}, 32'(a_valid), 32'(ea.valid));
        check({ea.tag, "/d64 err"},   32'(a_err),   32'(ea.err));
        check({ea.tag, "/d64 busy"},  32'(a_busy),  32'(ea.busy));
      end
      if (q1.size() > 0) begin
        eb = q1.pop_front();
        check({eb.tag, "/d48 out"},   32'(b_out),   32'(eb.out));
        check({eb.tag, "/d48 pc"},    32'(b_pc),    32'(eb.pc));
        check({eb.tag, "/d48 valid"}, 32'(b_valid), 32'(eb.valid));
        check({eb.tag, "/d48 err"},   32'(b_err),   32'(eb.err));
        check({eb.tag, "/d48 busy"},  32'(b_busy),  32'(eb.busy));
      end
    end
  end

  initial begin
    logic [AW-1:0] r_pc, r_wa;
    rst_n = 1'b0;
    req = 1'b0; stall = 1'b0; flush = 1'b0; we = 1'b0;
    pc = '0; waddr = '0; wdata = '0;

    g_tag = "reset";
    do_reset(3);

    // Clear sweep with noise on every control input; it must be ignored.
    g_tag = "init";
    for (int i = 0; i < 64; i++)
      drive(1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 6'($urandom), 16'($urandom));
    idle(2);

    g_tag = "fetch_all";
    for (int i = 0; i < 64; i++) drive(1'b1, 6'(i), 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    g_tag = "load";
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 6'd5, 16'h1234);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 6'd6, 16'hABCD);
    drive(1'b1, 6'd5, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 6'd6, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    g_tag = "stall";
    drive(1'b1, 6'd5, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) drive(1'b1, 6'd9, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(1);

    g_tag = "flush";
    drive(1'b1, 6'd6, 1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 6'd6, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    g_tag = "wfirst";
    drive(1'b1, 6'd7, 1'b0, 1'b0, 1'b1, 6'd7, 16'hBEEF);
    idle(1);

    g_tag = "range";
    drive(1'b1, 6'd50, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 6'd50, 16'h1111);
    drive(1'b1, 6'd50, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 6'd63, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    // Reset part-way through the sweep restarts it from word 0.
    g_tag = "midinit";
    do_reset(2);
    idle(20);
    do_reset(2);
    idle(70);

    g_tag = "random";
    for (int i = 0; i < 400; i++) begin
      r_wa = 6'($urandom);
      r_pc = ($urandom_range(0, 3) == 0) ? r_wa : 6'($urandom);
      drive(1'($urandom_range(0, 3) != 0), r_pc,
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) == 0), r_wa, 16'($urandom));
    end
    idle(3);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
